wb2uart_host: RTL and testbench
===============================

Name: wb2uart_host

Overview:
- Wishbone slave that tunnels single-byte bus accesses over UART to the remote uart2wb bridge; it is the host/initiator end of the same ASCII command protocol.
- Encodes each access as ASCII commands on the UART TX side and decodes the two-character hex read reply from the UART RX side.
- Sits between a local bus master (CPU or test controller) and a uart_tx/uart_rx pair wired to the remote board.

Parameters:
- TIMEOUT, 1000000, cycles to wait for each read-reply character before aborting.
- TW, 20, width of the timeout counter; must hold TIMEOUT.

Ports:
- i_wb_clk  in  1  clock.
- i_wb_rst_n  in  1  reset: synchronous, active-low.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe; held by the master until ack or err.
- i_wb_we  in  1  1 = write.
- i_wb_addr  in  24  byte address.
- i_wb_dat  in  8  write data.
- o_wb_dat  out  8  read data; valid with o_wb_ack.
- o_wb_ack  out  1  one-cycle completion pulse.
- o_wb_err  out  1  one-cycle error pulse (timeout or bad reply).
- tx_dat  out  8  character to transmit.
- send  out  1  one-cycle TX start pulse.
- tx_busy  in  1  UART TX busy; may assert one cycle after send.
- rx_dat  in  8  received character.
- received  in  1  one-cycle RX strobe.

Behaviour:
- Reset (i_wb_rst_n==0 at a clock edge): o_wb_ack=0, o_wb_err=0, send=0, tx_dat=0x00, o_wb_dat=0x00, shadow_valid=0, state=SYNC. Reset applies mid-operation and drops any pending access without ack.
- Character emit sequence (used for every TX character): drive tx_dat, pulse send for 1 cycle, wait 1 cycle, then wait until tx_busy==0. Only after that does the next character start.
- Hex encoding: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase only).
- Hex decoding: only 0x30-0x39 and 0x41-0x46 are valid; any other character is invalid.
- States:
  - SYNC: emit '.' (0x2E), then go to IDLE.
  - IDLE: on i_wb_cyc&&i_wb_stb, latch addr, we and dat. If shadow_valid && shadow_addr==addr, go to CMD; otherwise go to ADDR.
  - ADDR: emit 'p' (0x70), then six nibbles in this order: a[7:4], a[3:0], a[15:12], a[11:8], a[23:20], a[19:16]. Set shadow_addr=addr, then go to CMD.
  - CMD, write: emit 'w' (0x77), hi nibble, lo nibble, then go to DONE.
  - CMD, read: emit 'r' (0x72), clear the timeout counter, then go to RHI.
  - RHI/RLO: on received, decode rx_dat into data[7:4] or data[3:0] and reset the counter. From RLO go to DONE.
  - RHI/RLO invalid character: pulse o_wb_err, clear shadow_valid, go to SYNC.
  - RHI/RLO timeout (counter reaches TIMEOUT): same action as an invalid character.
  - received strobes outside RHI/RLO are ignored.
  - DONE: pulse o_wb_ack for 1 cycle; o_wb_dat=data on reads. Set shadow_addr=addr+1 (24-bit, 0xFFFFFF wraps to 0x000000), set shadow_valid=1, go to IDLE.
- At most one access is in flight. stb dropping before ack is a master protocol violation; the block still completes the UART transaction.
- IDLE accepts a new request in the cycle after ack, not the same cycle.
- Write latency with matching shadow: 3 characters, plus 1 cycle for ack.
- o_wb_dat holds its value between reads.

Decomposition:
- Shared package: protocol character constants (CH_RESET=0x2E, CH_ADDR=0x70, CH_READ=0x72, CH_WRITE=0x77), state encodings, nibble emission order.
- Sub-module hex_ascii_codec: combinational nibble->ASCII and ASCII->{valid, nibble}. Also reusable by uart2wb.

Test Plan:
- Reset released -> exactly one '.' (0x2E) sent, then idle with send low.
- Write addr 0x123456, dat 0xA5 -> TX "p563412wA5", then one ack.
- Write addr 0x123457, dat 0x3C -> TX "w3C" only (no 'p'), then ack.
- Read addr 0x123458, RX model replies "7E" -> TX "r" only, then ack with o_wb_dat=0x7E.
- Read addr 0xFFFFFF (reply "01"), then read 0x000000 (reply "02") -> second read sends no 'p' (wrap); acks return 0x01 and 0x02.
- Read where RX replies 'x' -> err pulse, '.' sent; next access to the same address re-sends the 'p' sequence.
- Read with no reply -> err pulse after TIMEOUT cycles.
- Reset asserted mid-ADDR -> no ack, '.' sent after release.

Source files
------------

// File: rtl/wb2uart_host_pkg.sv
// Shared definitions for the Wishbone-to-UART host bridge:
// protocol characters, state encodings and address nibble order.
package wb2uart_host_pkg;

   localparam logic [7:0] CH_RESET = 8'h2E;
   localparam logic [7:0] CH_ADDR  = 8'h70;
   localparam logic [7:0] CH_READ  = 8'h72;
   localparam logic [7:0] CH_WRITE = 8'h77;

   localparam logic [2:0] LAST_ADDR = 3'd6;
   localparam logic [2:0] LAST_WR   = 3'd2;

   typedef enum logic [2:0] {
      S_SYNC, S_IDLE, S_ADDR, S_CMD, S_RHI, S_RLO, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_SEND, PH_GAP, PH_BUSY
   } phase_t;

   // low byte first, high nibble of each byte first
   function automatic logic [3:0] addr_nib(input logic [23:0] a,
                                           input logic [2:0]  k);
      logic [3:0] n;
      unique case (k)
         3'd0:    n = a[7:4];
         3'd1:    n = a[3:0];
         3'd2:    n = a[15:12];
         3'd3:    n = a[11:8];
         3'd4:    n = a[23:20];
         default: n = a[19:16];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/wb2uart_host_if.sv
// Wishbone slave bundle for the UART host bridge.
interface wb2uart_host_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [23:0] i_wb_addr;
   logic [7:0]  i_wb_dat;
   logic [7:0]  o_wb_dat;
   logic        o_wb_ack;
   logic        o_wb_err;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_dat,
      input  o_wb_dat, o_wb_ack, o_wb_err
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_dat,
      output o_wb_dat, o_wb_ack, o_wb_err
   );
endinterface

// File: rtl/wb2uart_host_hex_ascii_codec.sv
// Combinational nibble <-> uppercase ASCII hex conversion.
module hex_ascii_codec (
   input  logic [3:0] i_nib,
   output logic [7:0] o_asc,
   input  logic [7:0] i_asc,
   output logic       o_valid,
   output logic [3:0] o_nib
);

   assign o_asc = (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib})
                                  : (8'h37 + {4'h0, i_nib});

   always_comb begin
      o_valid = 1'b0;
      o_nib   = 4'h0;
      unique case (1'b1)
         (i_asc >= 8'h30 && i_asc <= 8'h39): begin
            o_valid = 1'b1;
            o_nib   = i_asc[3:0];
         end
         (i_asc >= 8'h41 && i_asc <= 8'h46): begin
            o_valid = 1'b1;
            o_nib   = i_asc[3:0] + 4'd9;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/wb2uart_host.sv
// Wishbone slave that tunnels byte accesses over a UART link
// as ASCII commands and decodes the hex read reply.
module wb2uart_host
   import wb2uart_host_pkg::*;
#(
   parameter int TIMEOUT = 1000000,
   parameter int TW      = 20
) (
   input  logic              i_wb_clk,
   input  logic              i_wb_rst_n,
   wb2uart_host_if.slave     wb,
   output logic [7:0]        tx_dat,
   output logic              send,
   input  logic              tx_busy,
   input  logic [7:0]        rx_dat,
   input  logic              received
);

   state_t          r_state, w_state_n;
   phase_t          r_ph, w_ph_n;
   logic [2:0]      r_idx, w_idx_n;
   logic [7:0]      r_tx_dat, w_tx_n;
   logic            r_send, w_send_n;
   logic            r_ack, w_ack_n;
   logic            r_err, w_err_n;
   logic [7:0]      r_rdat, w_rdat_n;
   logic [23:0]     r_addr, w_addr_n;
   logic            r_we, w_we_n;
   logic [7:0]      r_dat, w_dat_n;
   logic [23:0]     r_sh_addr, w_sh_addr_n;
   logic            r_sh_vld, w_sh_vld_n;
   logic [7:0]      r_data, w_data_n;
   logic [TW-1:0]   r_cnt, w_cnt_n;

   logic [3:0]      w_nib;
   logic [7:0]      w_hex;
   logic [7:0]      w_char;
   logic            w_last;
   logic            w_rx_vld;
   logic [3:0]      w_rx_nib;

   hex_ascii_codec u_codec (
      .i_nib   (w_nib),
      .o_asc   (w_hex),
      .i_asc   (rx_dat),
      .o_valid (w_rx_vld),
      .o_nib   (w_rx_nib)
   );

   assign tx_dat      = r_tx_dat;
   assign send        = r_send;
   assign wb.o_wb_dat = r_rdat;
   assign wb.o_wb_ack = r_ack;
   assign wb.o_wb_err = r_err;

   // index 0 is the command letter, hex digits follow
   always_comb begin
      if (r_state == S_ADDR)
         w_nib = addr_nib(r_addr, r_idx - 3'd1);
      else
         w_nib = (r_idx == 3'd1) ? r_dat[7:4] : r_dat[3:0];
   end

   always_comb begin
      w_char = CH_RESET;
      w_last = 1'b1;
      unique case (r_state)
         S_ADDR: begin
            w_char = (r_idx == 3'd0) ? CH_ADDR : w_hex;
            w_last = (r_idx == LAST_ADDR);
         end
         S_CMD: begin
            if (r_we) begin
               w_char = (r_idx == 3'd0) ? CH_WRITE : w_hex;
               w_last = (r_idx == LAST_WR);
            end else begin
               w_char = CH_READ;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_n   = r_state;
      w_ph_n      = r_ph;
      w_idx_n     = r_idx;
      w_send_n    = 1'b0;
      w_tx_n      = r_tx_dat;
      w_ack_n     = 1'b0;
      w_err_n     = 1'b0;
      w_rdat_n    = r_rdat;
      w_addr_n    = r_addr;
      w_we_n      = r_we;
      w_dat_n     = r_dat;
      w_sh_addr_n = r_sh_addr;
      w_sh_vld_n  = r_sh_vld;
      w_data_n    = r_data;
      w_cnt_n     = r_cnt;
      unique case (r_state)
         S_SYNC, S_ADDR, S_CMD: begin
            unique case (r_ph)
               PH_SEND: begin
                  w_send_n = 1'b1;
                  w_tx_n   = w_char;
                  w_ph_n   = PH_GAP;
               end
               PH_GAP: w_ph_n = PH_BUSY;
               default: begin
                  if (!tx_busy) begin
                     w_ph_n  = PH_SEND;
                     w_idx_n = r_idx + 3'd1;
                     if (w_last) begin
                        w_idx_n = 3'd0;
                        if (r_state == S_SYNC) begin
                           w_state_n = S_IDLE;
                        end else if (r_state == S_ADDR) begin
                           w_sh_addr_n = r_addr;
                           w_state_n   = S_CMD;
                        end else if (r_we) begin
                           w_state_n = S_DONE;
                        end else begin
                           w_cnt_n   = '0;
                           w_state_n = S_RHI;
                        end
                     end
                  end
               end
            endcase
         end
         S_IDLE: begin
            // r_ack gate: no new request in the ack cycle itself
            if (wb.i_wb_cyc && wb.i_wb_stb && !r_ack) begin
               w_addr_n = wb.i_wb_addr;
               w_we_n   = wb.i_wb_we;
               w_dat_n  = wb.i_wb_dat;
               w_idx_n  = 3'd0;
               w_ph_n   = PH_SEND;
               if (r_sh_vld && r_sh_addr == wb.i_wb_addr)
                  w_state_n = S_CMD;
               else
                  w_state_n = S_ADDR;
            end
         end
         S_RHI, S_RLO: begin
            if (received && w_rx_vld) begin
               w_cnt_n = '0;
               if (r_state == S_RHI) begin
                  w_data_n[7:4] = w_rx_nib;
                  w_state_n     = S_RLO;
               end else begin
                  w_data_n[3:0] = w_rx_nib;
                  w_state_n     = S_DONE;
               end
            end else if (received || r_cnt == TW'(TIMEOUT)) begin
               w_err_n    = 1'b1;
               w_sh_vld_n = 1'b0;
               w_cnt_n    = '0;
               w_ph_n     = PH_SEND;
               w_idx_n    = 3'd0;
               w_state_n  = S_SYNC;
            end else begin
               w_cnt_n = r_cnt + TW'(1);
            end
         end
         S_DONE: begin
            w_ack_n     = 1'b1;
            if (!r_we)
               w_rdat_n = r_data;
            w_sh_addr_n = r_addr + 24'd1;
            w_sh_vld_n  = 1'b1;
            w_state_n   = S_IDLE;
         end
         default: w_state_n = S_SYNC;
      endcase
   end

   always_ff @(posedge i_wb_clk) begin
      if (!i_wb_rst_n) begin
         r_state   <= S_SYNC;
         r_ph      <= PH_SEND;
         r_idx     <= 3'd0;
         r_tx_dat  <= 8'h00;
         r_send    <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rdat    <= 8'h00;
         r_addr    <= 24'h0;
         r_we      <= 1'b0;
         r_dat     <= 8'h00;
         r_sh_addr <= 24'h0;
         r_sh_vld  <= 1'b0;
         r_data    <= 8'h00;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_n;
         r_ph      <= w_ph_n;
         r_idx     <= w_idx_n;
         r_tx_dat  <= w_tx_n;
         r_send    <= w_send_n;
         r_ack     <= w_ack_n;
         r_err     <= w_err_n;
         r_rdat    <= w_rdat_n;
         r_addr    <= w_addr_n;
         r_we      <= w_we_n;
         r_dat     <= w_dat_n;
         r_sh_addr <= w_sh_addr_n;
         r_sh_vld  <= w_sh_vld_n;
         r_data    <= w_data_n;
         r_cnt     <= w_cnt_n;
      end
   end

endmodule

// File: tb/tb_wb2uart_host.sv
// Self-checking bench for wb2uart_host with a UART link model
// and a shadow-address reference model.
module tb_wb2uart_host;

   localparam int TO = 200;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [7:0] tx_dat;
   logic       send;
   logic       tx_busy  = 1'b0;
   logic [7:0] rx_dat   = 8'h00;
   logic       received = 1'b0;

   always #5 clk = ~clk;

   wb2uart_host_if bus ();

   wb2uart_host #(.TIMEOUT(TO), .TW(20)) dut (
      .i_wb_clk   (clk),
      .i_wb_rst_n (rst_n),
      .wb         (bus),
      .tx_dat     (tx_dat),
      .send       (send),
      .tx_busy    (tx_busy),
      .rx_dat     (rx_dat),
      .received   (received)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ack_cnt  = 0;
   int busy_cnt = 0;

   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];

   bit          m_sv = 1'b0;
   logic [23:0] m_sa = 24'h0;

   string HEX = "0123456789ABCDEF";

   // UART TX model: capture characters, hold busy a random time
   always @(negedge clk) begin
      if (bus.o_wb_ack === 1'b1) ack_cnt++;
      if (send === 1'b1) begin
         tx_q.push_back(tx_dat);
         busy_cnt = $urandom_range(0, 6);
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      tx_busy = (busy_cnt > 0);
   end

   function automatic logic [7:0] hx(input logic [3:0] n);
      return HEX[n];
   endfunction

   task automatic build_exp(input bit we, input logic [23:0] a,
                            input logic [7:0] d);
      exp_q.delete();
      if (!(m_sv && m_sa == a)) begin
         exp_q.push_back(8'h70);
         for (int b = 0; b < 3; b++) begin
            exp_q.push_back(hx(4'((a >> (8*b + 4)) & 24'hF)));
            exp_q.push_back(hx(4'((a >> (8*b)) & 24'hF)));
         end
      end
      if (we) begin
         exp_q.push_back(8'h77);
         exp_q.push_back(hx(d[7:4]));
         exp_q.push_back(hx(d[3:0]));
      end else begin
         exp_q.push_back(8'h72);
      end
   endtask

   task automatic wait_quiet(input string name);
      int q = 0;
      for (int i = 0; i < 400 && q < 12; i++) begin
         @(negedge clk);
         if (!send && !tx_busy) q++;
         else q = 0;
      end
      n_checks++;
      if (q < 12) begin
         n_fail++;
         $display("FAIL %s quiet: link still active, required idle", name);
      end
   endtask

   task automatic check_tx(input string name);
      string g = "";
      string e = "";
      foreach (tx_q[i]) g = {g, $sformatf("%02h ", tx_q[i])};
      foreach (exp_q[i]) e = {e, $sformatf("%02h ", exp_q[i])};
      n_checks++;
      if (g != e) begin
         n_fail++;
         $display("FAIL %s tx: got [%s] required [%s]", name, g, e);
      end
   endtask

   // mode 0: good reply, 1: invalid char, 2: no reply
   task automatic access(input bit we, input logic [23:0] a,
                         input logic [7:0] d, input int mode,
                         input logic [7:0] rep, input string name);
      int t;
      int r_at = -1;
      int nxt = 0;
      bit got_ack = 0;
      bit got_err = 0;
      logic [7:0] got_dat = 8'h00;
      logic [7:0] rq[$];
      if (mode == 0) begin
         rq.push_back(hx(rep[7:4]));
         rq.push_back(hx(rep[3:0]));
      end else if (mode == 1) begin
         rq.push_back(8'h78);
      end
      build_exp(we, a, d);
      tx_q.delete();
      @(negedge clk);
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = we;
      bus.i_wb_addr = a;
      bus.i_wb_dat  = d;
      for (t = 0; t < TO * 3 + 400 && !got_ack && !got_err; t++) begin
         @(negedge clk);
         received = 1'b0;
         if (bus.o_wb_ack === 1'b1) begin
            got_ack = 1;
            got_dat = bus.o_wb_dat;
         end
         if (bus.o_wb_err === 1'b1) got_err = 1;
         if (!we && r_at < 0 && tx_q.size() == exp_q.size() && !tx_busy) begin
            r_at = t;
            nxt  = t + 3;
         end
         if (r_at >= 0 && rq.size() > 0 && t >= nxt && !got_ack && !got_err) begin
            rx_dat   = rq.pop_front();
            received = 1'b1;
            nxt      = t + 3;
         end
      end
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      received     = 1'b0;
      n_checks++;
      if (mode == 0 && !(got_ack && !got_err)) begin
         n_fail++;
         $display("FAIL %s ack: ack=%0b err=%0b, required ack=1 err=0",
                  name, got_ack, got_err);
      end else if (mode != 0 && !(got_err && !got_ack)) begin
         n_fail++;
         $display("FAIL %s err: ack=%0b err=%0b, required ack=0 err=1",
                  name, got_ack, got_err);
      end
      @(negedge clk);
      n_checks++;
      if (bus.o_wb_ack !== 1'b0 || bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pulse: ack=%b err=%b after one cycle, required 0 0",
                  name, bus.o_wb_ack, bus.o_wb_err);
      end
      if (mode == 0 && !we) begin
         n_checks++;
         if (got_dat !== rep) begin
            n_fail++;
            $display("FAIL %s rdata: got %02h required %02h", name, got_dat, rep);
         end
      end
      if (mode == 2) begin
         n_checks++;
         if (r_at < 0 || (t - r_at) < TO || (t - r_at) > TO + 12) begin
            n_fail++;
            $display("FAIL %s timeout: err after %0d cycles, required about %0d",
                     name, t - r_at, TO);
         end
      end
      if (mode != 0) exp_q.push_back(8'h2E);
      wait_quiet(name);
      check_tx(name);
      if (mode == 0) begin
         m_sv = 1'b1;
         m_sa = a + 24'd1;
      end else begin
         m_sv = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.o_wb_ack !== 1'b0 || bus.o_wb_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ack_err: ack=%b err=%b required 0 0",
                  bus.o_wb_ack, bus.o_wb_err);
      end
      n_checks++;
      if (send !== 1'b0 || tx_dat !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_tx: send=%b tx_dat=%02h required 0 00", send, tx_dat);
      end
      n_checks++;
      if (bus.o_wb_dat !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rdat: got %02h required 00", bus.o_wb_dat);
      end
      tx_q.delete();
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h2E);
      wait_quiet("reset");
      check_tx("reset_sync");
      n_checks++;
      if (send !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_send: got %b required 0", send);
      end
      m_sv = 1'b0;
   endtask

   task automatic test_basic();
      access(1'b1, 24'h123456, 8'hA5, 0, 8'h00, "write_new");
      access(1'b1, 24'h123457, 8'h3C, 0, 8'h00, "write_shadow");
      access(1'b0, 24'h123458, 8'h00, 0, 8'h7E, "read_shadow");
      access(1'b1, 24'h123459, 8'h11, 0, 8'h00, "write_hold");
      n_checks++;
      if (bus.o_wb_dat !== 8'h7E) begin
         n_fail++;
         $display("FAIL rdata_hold: got %02h required 7e", bus.o_wb_dat);
      end
   endtask

   task automatic test_wrap();
      access(1'b0, 24'hFFFFFF, 8'h00, 0, 8'h01, "read_top");
      access(1'b0, 24'h000000, 8'h00, 0, 8'h02, "read_wrap");
   endtask

   task automatic test_errors();
      access(1'b0, 24'h000001, 8'h00, 1, 8'h00, "bad_reply");
      access(1'b1, 24'h000001, 8'h5A, 0, 8'h00, "resend_p");
      access(1'b0, 24'h000002, 8'h00, 2, 8'h00, "timeout");
   endtask

   task automatic test_reset_mid();
      int a0;
      int k;
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = 1'b1;
      bus.i_wb_addr = 24'hABCDEF;
      bus.i_wb_dat  = 8'h99;
      tx_q.delete();
      a0 = ack_cnt;
      for (k = 0; k < 300 && tx_q.size() < 3; k++) @(negedge clk);
      n_checks++;
      if (tx_q.size() < 3) begin
         n_fail++;
         $display("FAIL mid_reset_start: %0d chars sent, required 3", tx_q.size());
      end
      rst_n = 1'b0;
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      repeat (2) @(negedge clk);
      tx_q.delete();
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h2E);
      wait_quiet("mid_reset");
      check_tx("mid_reset_sync");
      n_checks++;
      if (ack_cnt != a0) begin
         n_fail++;
         $display("FAIL mid_reset_ack: %0d acks seen, required 0", ack_cnt - a0);
      end
      m_sv = 1'b0;
      access(1'b1, 24'hABCDEF, 8'h99, 0, 8'h00, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         int sel;
         logic [23:0] a;
         bit we;
         sel = $urandom_range(0, 3);
         we  = 1'($urandom_range(0, 1));
         if (sel <= 1) a = m_sa;
         else if (sel == 2) a = 24'($urandom);
         else a = m_sa - 24'd1;
         access(we, a, 8'($urandom), 0, 8'($urandom),
                $sformatf("random_%0d", i));
      end
   endtask

   initial begin
      bus.i_wb_cyc  = 1'b0;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = 24'h0;
      bus.i_wb_dat  = 8'h00;
      test_reset();
      test_basic();
      test_wrap();
      test_errors();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
